// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem handshake,
// buffers the returned word for IF/ID and applies decode redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic [1:0]  PCSrcD,
    input  logic [31:0] BranchTargetD,
    input  logic [31:0] JumpTargetD,
    input  logic [31:0] JrTargetD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dout,
    output logic [31:0] PC4F,
    output logic [31:0] PCF,
    output logic        FetchBusy
);

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t      state;
    logic        kill;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc4;
    logic        redirect;
    logic [31:0] target;
    logic        handshake;

    // Redirect is gated by the hazard stall; target follows PCSrcD.
    always_comb begin
        redirect = (PCSrcD != 2'b00) && !StallF;
        case (PCSrcD)
            2'b01:   target = BranchTargetD;
            2'b10:   target = JumpTargetD;
            2'b11:   target = JrTargetD;
            default: target = 32'(PCF + PC_STEP);
        endcase
    end

    assign handshake = imem_req & imem_ready;
    assign imem_addr = PCF;
    assign FetchBusy = (state != HOLD);

    // A redirect in HOLD squashes the buffered word in the same cycle.
    assign dout = (state == HOLD && !redirect) ? buf_instr : 32'd0;
    assign PC4F = (state == HOLD && !redirect) ? buf_pc4   : 32'd0;

    // imem_req is registered: low in reset, raised on the first edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PCF       <= RESET_PC;
            state     <= IDLE;
            kill      <= 1'b0;
            buf_instr <= 32'd0;
            buf_pc4   <= 32'd0;
            imem_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        kill     <= redirect;
                    end else begin
                        imem_req <= 1'b1;
                    end
                    if (redirect) begin
                        PCF <= target;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill || redirect) begin
                            state    <= IDLE;
                            kill     <= 1'b0;
                            imem_req <= 1'b1;
                        end else begin
                            buf_instr <= imem_rdata;
                            buf_pc4   <= 32'(PCF + PC_STEP);
                            state     <= HOLD;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                    if (redirect) begin
                        PCF <= target;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        PCF       <= target;
                        buf_instr <= 32'd0;
                        buf_pc4   <= 32'd0;
                        state     <= IDLE;
                        imem_req  <= 1'b1;
                    end else if (!StallF) begin
                        PCF      <= 32'(PCF + PC_STEP);
                        state    <= IDLE;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    kill     <= 1'b0;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
